cluster_core_data_buffer: RTL and testbench



---
 rtl/pulp_cluster_package.sv | 22 ++
 rtl/cluster_data_req_fifo.sv | 52 +++++
 rtl/cluster_core_data_buffer.sv | 120 ++++++++++++
 tb/tb_cluster_core_data_buffer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulp_cluster_package.sv
// Shared cluster types: core data port request/response bundles
// and data buffer defaults.
package pulp_cluster_package;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;

  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } core_data_rsp_t;

  localparam int DataBufDefaultDepth          = 2;
  localparam int DataBufDefaultMaxOutstanding = 4;

endpackage

// File: rtl/cluster_data_req_fifo.sv
// Fall-through-free request FIFO; pointers carry a wrap bit
// so full and empty are told apart without a counter.
module cluster_data_req_fifo
  import pulp_cluster_package::*;
#(
  parameter int Depth = DataBufDefaultDepth
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  core_data_req_t data_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output core_data_req_t head_o
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [AW:0]    wptr_q;
  logic [AW:0]    rptr_q;
  core_data_req_t mem_q [Depth];

  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(Depth - 1))
      return {~p[AW], {AW{1'b0}}};
    return p + 1'b1;
  endfunction

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o)
        wptr_q <= ptr_inc(wptr_q);
      if (pop_i && !empty_o)
        rptr_q <= ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o)
      mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cluster_core_data_buffer.sv
// Elastic per-core data buffer: request FIFO, in-flight limit, registered
// responses. CLUSTER_DATA_BUF_STATS_EN adds stall/accept counters.
module cluster_core_data_buffer
  import pulp_cluster_package::*;
#(
  parameter int  ReqFifoDepth   = DataBufDefaultDepth,
  parameter int  MaxOutstanding = DataBufDefaultMaxOutstanding,
  localparam int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  core_data_req_t      core_req_i,
  output core_data_rsp_t      core_rsp_o,
  output core_data_req_t      mem_req_o,
  input  core_data_rsp_t      mem_rsp_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                idle_o,
  output logic                err_o
`ifdef CLUSTER_DATA_BUF_STATS_EN
  ,
  input  logic                clear_stats_i,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         req_cnt_o
`endif
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] OneCnt = CntWidth'(1);

  logic           fifo_full;
  logic           fifo_empty;
  core_data_req_t fifo_head;
  logic           gnt;
  logic           accept;
  logic           pop;
  logic [CntWidth-1:0] cnt_q;
  logic           r_valid_q;
  logic [31:0]    r_data_q;
  logic           err_q;
  logic           none_in_flight;

  // gnt is held low during reset so the whole response bundle reads zero
  assign gnt    = !rst_i && !fifo_full && (cnt_q < MaxCnt);
  assign accept = core_req_i.req && gnt;
  assign pop    = !fifo_empty && mem_rsp_i.gnt;

  cluster_data_req_fifo #(
    .Depth (ReqFifoDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (core_req_i),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    mem_req_o     = fifo_head;
    mem_req_o.req = !fifo_empty;
  end

  always_comb begin
    core_rsp_o         = '0;
    core_rsp_o.gnt     = gnt;
    core_rsp_o.r_data  = r_data_q;
    core_rsp_o.r_valid = r_valid_q;
  end

  // a response sitting in the output register is still counted
  assign none_in_flight = (cnt_q == '0) ||
                          ((cnt_q == OneCnt) && r_valid_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      r_valid_q <= mem_rsp_i.r_valid;
      if (mem_rsp_i.r_valid)
        r_data_q <= mem_rsp_i.r_data;
      if (accept && !r_valid_q) begin
        if (cnt_q != MaxCnt)
          cnt_q <= cnt_q + OneCnt;
      end else if (!accept && r_valid_q) begin
        if (cnt_q != '0)
          cnt_q <= cnt_q - OneCnt;
      end
      if ((mem_rsp_i.r_valid && none_in_flight) ||
          (mem_rsp_i.gnt && fifo_empty))
        err_q <= 1'b1;
    end
  end

  assign outstanding_o = cnt_q;
  assign idle_o        = fifo_empty && (cnt_q == '0);
  assign err_o         = err_q;

`ifdef CLUSTER_DATA_BUF_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      req_cnt_o   <= '0;
    end else if (clear_stats_i) begin
      stall_cnt_o <= '0;
      req_cnt_o   <= '0;
    end else begin
      if (core_req_i.req && !gnt)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (accept)
        req_cnt_o <= req_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cluster_core_data_buffer.sv
// Directed bench for cluster_core_data_buffer.
module tb_cluster_core_data_buffer;
  import pulp_cluster_package::*;

  logic           clk = 1'b0;
  logic           rst;
  core_data_req_t core_req;
  core_data_rsp_t core_rsp;
  core_data_req_t mem_req;
  core_data_rsp_t mem_rsp;
  logic [2:0]     outstanding;
  logic           idle;
  logic           err;
  logic           mem_ready;
  logic           gnt_force;
  logic           mem_rv;
  logic [31:0]    mem_rd;
`ifdef CLUSTER_DATA_BUF_STATS_EN
  logic           clear_stats;
  logic [31:0]    stall_cnt;
  logic [31:0]    req_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // the modelled demux only grants a pending request unless forced
  always_comb begin
    mem_rsp         = '0;
    mem_rsp.gnt     = (mem_ready && mem_req.req) || gnt_force;
    mem_rsp.r_data  = mem_rd;
    mem_rsp.r_valid = mem_rv;
  end

  cluster_core_data_buffer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .core_req_i    (core_req),
    .core_rsp_o    (core_rsp),
    .mem_req_o     (mem_req),
    .mem_rsp_i     (mem_rsp),
    .outstanding_o (outstanding),
    .idle_o        (idle),
    .err_o         (err)
`ifdef CLUSTER_DATA_BUF_STATS_EN
    ,
    .clear_stats_i (clear_stats),
    .stall_cnt_o   (stall_cnt),
    .req_cnt_o     (req_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_rsp(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rv = 1'b1;
      mem_rd = 32'h5000_0000 + i;
      tick();
    end
    mem_rv = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    core_req = '0;
    mem_ready = 1'b0;
    gnt_force = 1'b0;
    mem_rv = 1'b0;
    mem_rd = '0;
`ifdef CLUSTER_DATA_BUF_STATS_EN
    clear_stats = 1'b0;
`endif
    tick();
    tick();
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", outstanding); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL rst_idle got %b exp 1", idle); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", err); end
    tests++; if (core_rsp !== '0) begin fails++; $display("FAIL rst_core_rsp got %h exp 0", core_rsp); end
    tests++; if (mem_req.req !== 1'b0) begin fails++; $display("FAIL rst_mem_req got %b exp 0", mem_req.req); end
    rst = 1'b0;
    tick();
    tests++; if (core_rsp.gnt !== 1'b1) begin fails++; $display("FAIL post_rst_gnt got %b exp 1", core_rsp.gnt); end
  endtask

  task automatic test_single_write;
    mem_ready = 1'b1;
    core_req.req  = 1'b1;
    core_req.add  = 32'h1000_0010;
    core_req.we   = 1'b1;
    core_req.data = 32'hDEAD_BEEF;
    core_req.be   = 4'hF;
    tests++; if (core_rsp.gnt !== 1'b1) begin fails++; $display("FAIL sw_gnt got %b exp 1", core_rsp.gnt); end
    tests++; if (mem_req.req !== 1'b0) begin fails++; $display("FAIL sw_no_comb_path got %b exp 0", mem_req.req); end
    tick();
    core_req = '0;
    tests++; if (mem_req.req !== 1'b1) begin fails++; $display("FAIL sw_mem_req got %b exp 1", mem_req.req); end
    tests++; if (mem_req.add !== 32'h1000_0010) begin fails++; $display("FAIL sw_add got %h exp 10000010", mem_req.add); end
    tests++; if (mem_req.data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_data got %h exp deadbeef", mem_req.data); end
    tests++; if ({mem_req.we, mem_req.be} !== 5'h1F) begin fails++; $display("FAIL sw_we_be got %h exp 1f", {mem_req.we, mem_req.be}); end
    tests++; if (outstanding !== 3'd1) begin fails++; $display("FAIL sw_cnt1 got %0d exp 1", outstanding); end
    tests++; if (idle !== 1'b0) begin fails++; $display("FAIL sw_busy got %b exp 0", idle); end
    tick();
    tests++; if (mem_req.req !== 1'b0) begin fails++; $display("FAIL sw_popped got %b exp 0", mem_req.req); end
    tick();
    mem_rv = 1'b1;
    mem_rd = 32'h600D_F00D;
    tests++; if (core_rsp.r_valid !== 1'b0) begin fails++; $display("FAIL sw_rv_early got %b exp 0", core_rsp.r_valid); end
    tick();
    mem_rv = 1'b0;
    tests++; if (core_rsp.r_valid !== 1'b1) begin fails++; $display("FAIL sw_rv got %b exp 1", core_rsp.r_valid); end
    tests++; if (core_rsp.r_data !== 32'h600D_F00D) begin fails++; $display("FAIL sw_rdata got %h exp 600df00d", core_rsp.r_data); end
    tests++; if (outstanding !== 3'd1) begin fails++; $display("FAIL sw_cnt_reg got %0d exp 1", outstanding); end
    tick();
    tests++; if (core_rsp.r_valid !== 1'b0) begin fails++; $display("FAIL sw_rv_pulse got %b exp 0", core_rsp.r_valid); end
    tests++; if (core_rsp.r_data !== 32'h600D_F00D) begin fails++; $display("FAIL sw_rdata_hold got %h exp 600df00d", core_rsp.r_data); end
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL sw_cnt0 got %0d exp 0", outstanding); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL sw_idle got %b exp 1", idle); end
  endtask

  task automatic test_backpressure;
    int accepts;
    logic acc;
    accepts = 0;
    mem_ready = 1'b0;
    core_req.req  = 1'b1;
    core_req.add  = 32'h0000_1000;
    core_req.we   = 1'b0;
    core_req.data = 32'h0000_00A0;
    core_req.be   = 4'h3;
    for (int i = 0; i < 5; i++) begin
      tests++; if (core_rsp.gnt !== (i < 2)) begin fails++; $display("FAIL bp_gnt[%0d] got %b exp %b", i, core_rsp.gnt, (i < 2)); end
      if (i > 0) begin
        tests++; if ({mem_req.req, mem_req.add, mem_req.data} !== {1'b1, 32'h1000, 32'hA0}) begin fails++; $display("FAIL bp_stable[%0d] got %h/%h", i, mem_req.add, mem_req.data); end
      end
      acc = core_req.req && core_rsp.gnt;
      tick();
      if (acc) begin
        accepts++;
        core_req.data = core_req.data + 1;
        core_req.add  = core_req.add + 4;
      end
    end
    tests++; if (accepts !== 2) begin fails++; $display("FAIL bp_accepts got %0d exp 2", accepts); end
    core_req.req = 1'b0;
    mem_ready = 1'b1;
    tests++; if (mem_req.data !== 32'hA0) begin fails++; $display("FAIL bp_drain0 got %h exp a0", mem_req.data); end
    tick();
    tests++; if ({mem_req.req, mem_req.data} !== {1'b1, 32'hA1}) begin fails++; $display("FAIL bp_drain1 got %b/%h exp 1/a1", mem_req.req, mem_req.data); end
    tick();
    tests++; if (mem_req.req !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", mem_req.req); end
    tests++; if (outstanding !== 3'd2) begin fails++; $display("FAIL bp_cnt got %0d exp 2", outstanding); end
    drain_rsp(2);
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL bp_cnt_end got %0d exp 0", outstanding); end
  endtask

  task automatic test_max_outstanding;
    mem_ready = 1'b1;
    core_req.req  = 1'b1;
    core_req.add  = 32'h0000_2000;
    core_req.data = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      tests++; if (core_rsp.gnt !== (i < 4)) begin fails++; $display("FAIL mo_gnt[%0d] got %b exp %b", i, core_rsp.gnt, (i < 4)); end
      tick();
    end
    tests++; if (outstanding !== 3'd4) begin fails++; $display("FAIL mo_cnt got %0d exp 4", outstanding); end
    mem_rv = 1'b1;
    mem_rd = 32'hB0;
    tick();
    mem_rv = 1'b0;
    tests++; if ({core_rsp.r_valid, core_rsp.gnt} !== 2'b10) begin fails++; $display("FAIL mo_rv_nognt got %b exp 10", {core_rsp.r_valid, core_rsp.gnt}); end
    tests++; if (outstanding !== 3'd4) begin fails++; $display("FAIL mo_cnt_reg got %0d exp 4", outstanding); end
    tick();
    tests++; if (core_rsp.gnt !== 1'b1) begin fails++; $display("FAIL mo_gnt_back got %b exp 1", core_rsp.gnt); end
    tests++; if (outstanding !== 3'd3) begin fails++; $display("FAIL mo_cnt3 got %0d exp 3", outstanding); end
    core_req.req = 1'b0;
    drain_rsp(3);
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL mo_cnt_end got %0d exp 0", outstanding); end
  endtask

  task automatic test_back_to_back;
    mem_ready = 1'b1;
    core_req.req  = 1'b1;
    core_req.data = 32'h11;
    tick();
    core_req.data = 32'h22;
    tick();
    core_req.req = 1'b0;
    tests++; if (outstanding !== 3'd2) begin fails++; $display("FAIL bb_cnt_a got %0d exp 2", outstanding); end
    mem_rv = 1'b1;
    mem_rd = 32'h11;
    tick();
    tests++; if ({core_rsp.r_valid, core_rsp.r_data} !== {1'b1, 32'h11}) begin fails++; $display("FAIL bb_rsp11 got %b/%h exp 1/11", core_rsp.r_valid, core_rsp.r_data); end
    mem_rv = 1'b0;
    core_req.req  = 1'b1;
    core_req.data = 32'h33;
    tests++; if (core_rsp.gnt !== 1'b1) begin fails++; $display("FAIL bb_gnt got %b exp 1", core_rsp.gnt); end
    tick();
    core_req.req = 1'b0;
    tests++; if (outstanding !== 3'd2) begin fails++; $display("FAIL bb_cnt_same got %0d exp 2", outstanding); end
    mem_rv = 1'b1;
    mem_rd = 32'h22;
    tick();
    tests++; if (core_rsp.r_data !== 32'h22) begin fails++; $display("FAIL bb_rsp22 got %h exp 22", core_rsp.r_data); end
    mem_rd = 32'h33;
    tick();
    mem_rv = 1'b0;
    tests++; if (core_rsp.r_data !== 32'h33) begin fails++; $display("FAIL bb_rsp33 got %h exp 33", core_rsp.r_data); end
    tests++; if (outstanding !== 3'd1) begin fails++; $display("FAIL bb_cnt1 got %0d exp 1", outstanding); end
    tick();
    tests++; if ({idle, outstanding} !== 4'b1000) begin fails++; $display("FAIL bb_idle got %b/%0d exp 1/0", idle, outstanding); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL bb_no_err got %b exp 0", err); end
  endtask

  task automatic test_errors;
    mem_ready = 1'b0;
    mem_rv = 1'b1;
    mem_rd = 32'h0000_0BAD;
    tick();
    mem_rv = 1'b0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL er_spur got %b exp 1", err); end
    tests++; if ({core_rsp.r_valid, core_rsp.r_data} !== {1'b1, 32'hBAD}) begin fails++; $display("FAIL er_fwd got %b/%h exp 1/bad", core_rsp.r_valid, core_rsp.r_data); end
    tick();
    tick();
    tests++; if ({err, outstanding} !== 4'b1000) begin fails++; $display("FAIL er_sticky got %b/%0d exp 1/0", err, outstanding); end
    core_req.req = 1'b1;
    tick();
    tick();
    tests++; if (outstanding !== 3'd2) begin fails++; $display("FAIL er_burst got %0d exp 2", outstanding); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if ({outstanding, err, idle, mem_req.req} !== 6'b000010) begin fails++; $display("FAIL er_async_rst got %0d/%b/%b/%b exp 0/0/1/0", outstanding, err, idle, mem_req.req); end
    core_req.req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tests++; if ({err, mem_req.req, idle} !== 3'b001) begin fails++; $display("FAIL er_after_rst got %b exp 001", {err, mem_req.req, idle}); end
    gnt_force = 1'b1;
    tick();
    gnt_force = 1'b0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL er_gnt_noreq got %b exp 1", err); end
    tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL er_gnt_sticky got %b exp 1", err); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL er_clear got %b exp 0", err); end
    tick();
    rst = 1'b0;
    tick();
  endtask

`ifdef CLUSTER_DATA_BUF_STATS_EN
  task automatic test_stats;
    mem_ready = 1'b1;
    core_req.req = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    core_req.req = 1'b0;
    mem_rv = 1'b1;
    tick();
    mem_rv = 1'b0;
    tick();
    core_req.req = 1'b1;
    tick();
    core_req.req = 1'b0;
    tests++; if (stall_cnt !== 32'd3) begin fails++; $display("FAIL st_stall got %0d exp 3", stall_cnt); end
    tests++; if (req_cnt !== 32'd5) begin fails++; $display("FAIL st_req got %0d exp 5", req_cnt); end
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    tests++; if ({stall_cnt, req_cnt} !== 64'd0) begin fails++; $display("FAIL st_clear got %0d/%0d exp 0/0", stall_cnt, req_cnt); end
    drain_rsp(4);
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL st_cnt_end got %0d exp 0", outstanding); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_max_outstanding();
    test_back_to_back();
    test_errors();
`ifdef CLUSTER_DATA_BUF_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
